imem_prog_loader: RTL
=====================

// Module: imem_prog_loader
// PURPOSE
//   Sits downstream of the UART programming path. Accepts the word-write
//   strobes (ld_WE/ld_A/ld_WD) produced while programming mode is active and
//   buffers them in a small FIFO. Commits each word to the instruction-memory
//   write port, and owns the imem address mux between loader writes and CPU
//   fetch. Tracks committed word count and a running checksum, holds the CPU
//   stalled until every buffered word has landed, then pulses load_done.
// PARAMETERS
//   FIFO_DEPTH  4     entries in write FIFO (power of 2, >=2)
//   MEM_WORDS   1024  imem size in 32-bit words; byte addr >= MEM_WORDS*4 is out of range
// PORTS
//   CLK         in   1   system clock
//   reset       in   1   asynchronous, active-high reset
//   prog_mode   in   1   programming mode from UART control register
//   ld_WE       in   1   one-cycle word-write strobe from UART
//   ld_A        in   32  byte address of word to write
//   ld_WD       in   32  word to write
//   cpu_PC      in   32  CPU fetch address
//   mem_wready  in   1   imem write port accepts mem_WE this cycle
//   mem_A       out  32  imem address (FIFO head addr while writing, else cpu_PC)
//   mem_WD      out  32  imem write data (FIFO head data)
//   mem_WE      out  1   imem write enable
//   cpu_stall   out  1   hold CPU; high whenever state != IDLE
//   word_count  out  16  committed words since last load start (wraps at 2^16)
//   checksum    out  32  mod-2^32 sum of committed words
//   overflow    out  1   sticky: a strobe was dropped because the FIFO was full
//   addr_err    out  1   sticky: a strobe was dropped for bad address
//   load_done   out  1   one-cycle pulse when a load completes
// BEHAVIOUR
//   Reset: state IDLE, FIFO empty, mem_WE=0, cpu_stall=0, word_count=0,
//     checksum=0, overflow=0, addr_err=0, load_done=0; mem_A=cpu_PC, mem_WD=0.
//   States: IDLE, LOAD, DRAIN, DONE.
//     IDLE : prog_mode=1 -> LOAD. On that edge, clear word_count, checksum,
//            overflow and addr_err.
//     LOAD : prog_mode=0 and FIFO empty -> DONE; prog_mode=0 and FIFO
//            non-empty -> DRAIN.
//     DRAIN: prog_mode=1 -> LOAD, with no counter or flag clear; otherwise
//            FIFO empty (after this cycle's pop) -> DONE.
//     DONE : load_done=1 for exactly this cycle -> IDLE.
//   Push: ld_WE in LOAD or DRAIN. ld_WE in IDLE or DONE is ignored; no flag.
//     ld_A[1:0]!=0 or ld_A>=MEM_WORDS*4 -> drop, set addr_err.
//     FIFO full and no pop this cycle -> drop, set overflow.
//     Full with a pop in the same cycle -> push accepted.
//   Write out: mem_WE = FIFO non-empty and state in {LOAD, DRAIN}.
//     mem_A = head addr and mem_WD = head data while mem_WE=1; otherwise
//     mem_A = cpu_PC (combinational).
//     Pop = mem_WE & mem_wready. The pop also adds 1 to word_count and adds
//     head data to checksum (both wrap).
//   Latency: word pushed at edge N into an empty FIFO drives mem_WE during
//     cycle N+1. With mem_wready=1 continuously, throughput is 1 word/cycle.
//   Order: writes commit in strobe order; the FIFO pointers wrap mod FIFO_DEPTH.
//   cpu_stall = (state != IDLE), so it stays high through DONE and falls
//     the cycle after load_done.
//   mem_wready=0 holds the head word; mem_A, mem_WD and mem_WE stay stable.
//   Reset mid-load: FIFO contents are discarded and no further writes issue.
// TESTING
//   prog_mode 1, 3 strobes A=0,4,8 WD=1,2,3, mem_wready=1, prog_mode 0 ->
//     3 writes in order, word_count=3, checksum=6, one load_done, cpu_stall low after.
//   mem_wready=0 with 6 strobes (FIFO_DEPTH=4) -> first 4 buffered, overflow=1,
//     then mem_wready=1 -> exactly 4 writes commit.
//   Strobes A=0x2 and A=MEM_WORDS*4 -> no mem_WE, addr_err=1, word_count=0.
//   prog_mode drops with 2 words queued and mem_wready=0 -> DRAIN, cpu_stall held;
//     mem_wready=1 -> 2 writes, then load_done.
//   Full FIFO, push and pop in the same cycle -> push accepted, overflow stays 0.
//   Assert reset with 3 words queued -> mem_WE=0, all counters 0, cpu_stall=0, state IDLE.

Source files
------------

// File: rtl/imem_prog_loader.sv
// imem_prog_loader: buffers UART word-write strobes in a FIFO and commits them to imem, stalling the CPU until the load finishes
module imem_prog_loader #(
  parameter int FIFO_DEPTH = 4,
  parameter int MEM_WORDS  = 1024
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        prog_mode,
  input  logic        ld_WE,
  input  logic [31:0] ld_A,
  input  logic [31:0] ld_WD,
  input  logic [31:0] cpu_PC,
  input  logic        mem_wready,
  output logic [31:0] mem_A,
  output logic [31:0] mem_WD,
  output logic        mem_WE,
  output logic        cpu_stall,
  output logic [15:0] word_count,
  output logic [31:0] checksum,
  output logic        overflow,
  output logic        addr_err,
  output logic        load_done
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [31:0] A_LIM = 32'(MEM_WORDS * 4);
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [31:0] f_addr [FIFO_DEPTH];
  logic [31:0] f_data [FIFO_DEPTH];
  logic [AW:0] wp, rp, occ, occ_nx;
  logic active, empty, full, pop, push, strobe, addr_ok, start;
  assign occ     = wp - rp;
  assign empty   = occ == '0;
  assign full    = occ == (AW+1)'(FIFO_DEPTH);
  assign active  = state == LOAD || state == DRAIN;
  assign mem_WE  = active && !empty;
  assign pop     = mem_WE && mem_wready;
  assign strobe  = ld_WE && active;
  assign addr_ok = ld_A[1:0] == 2'b00 && ld_A < A_LIM;
  // A full FIFO still accepts a push when the head retires on the same edge
  assign push    = strobe && addr_ok && (!full || pop);
  assign occ_nx  = occ + (AW+1)'(push) - (AW+1)'(pop);
  assign start   = state == IDLE && prog_mode;
  assign mem_A   = mem_WE ? f_addr[rp[AW-1:0]] : cpu_PC;
  assign mem_WD  = mem_WE ? f_data[rp[AW-1:0]] : '0;
  assign cpu_stall = state != IDLE;
  assign load_done = state == DONE;
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  state_nx = prog_mode ? LOAD : IDLE;
      LOAD:  state_nx = prog_mode ? LOAD : (empty ? DONE : DRAIN);
      DRAIN: state_nx = prog_mode ? LOAD : (occ_nx == '0 ? DONE : DRAIN);
      DONE:  state_nx = IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      wp         <= '0;
      rp         <= '0;
      word_count <= '0;
      checksum   <= '0;
      overflow   <= 1'b0;
      addr_err   <= 1'b0;
    end else begin
      state <= state_nx;
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      if (start) begin
        word_count <= '0;
        checksum   <= '0;
        overflow   <= 1'b0;
        addr_err   <= 1'b0;
      end else begin
        if (pop) begin
          word_count <= word_count + 16'd1;
          checksum   <= checksum + mem_WD;
        end
        if (strobe && !addr_ok) addr_err <= 1'b1;
        if (strobe && addr_ok && full && !pop) overflow <= 1'b1;
      end
    end
  end
  always_ff @(posedge CLK) begin
    if (push) begin
      f_addr[wp[AW-1:0]] <= ld_A;
      f_data[wp[AW-1:0]] <= ld_WD;
    end
  end
endmodule
